// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: start/data request from the frame source and ready/busy/done status back from uart_tx_frame
interface uart_tx_frame_if #(parameter int DATA_BITS = 8);
  logic i_start_trigger;
  logic [DATA_BITS-1:0] i_tx_data;
  logic o_tx_ready;
  logic o_tx_busy;
  logic o_tx_done;
  modport master (output i_start_trigger, i_tx_data, input o_tx_ready, o_tx_busy, o_tx_done);
  modport slave (input i_start_trigger, i_tx_data, output o_tx_ready, o_tx_busy, o_tx_done);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: LSB-first UART frame serialiser on an oversampled baud tick; ports clk, reset, i_baud_tick, o_tx, bus (start/data in, ready/busy/done out); define UART_TX_BREAK_EN to add i_break line-break input
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_baud_tick,
`ifdef UART_TX_BREAK_EN
  input  logic i_break,
`endif
  output logic o_tx,
  uart_tx_frame_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t state, state_next;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic parity, brk, accept, bit_end, last_data, last_stop, tx_d, busy_d, done_d;
`ifdef UART_TX_BREAK_EN
  assign brk = i_break;
`else
  assign brk = 1'b0;
`endif
  assign bus.o_tx_ready = state == IDLE && !bus.o_tx_busy && !brk;
  assign accept = bus.i_start_trigger && bus.o_tx_ready;
  assign bit_end = i_baud_tick && tick_cnt == TW'(OVERSAMPLE - 1);
  assign last_data = bit_cnt == BW'(DATA_BITS - 1);
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? WAIT : IDLE;
      WAIT:    if (i_baud_tick) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && last_data) state_next = PARITY_MODE != 0 ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // busy stays high through the done cycle so ready is low while done pulses
  always_comb begin
    tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? parity : !(state == IDLE && brk);
    busy_d = state != IDLE || accept || brk;
    done_d = state == STOP && bit_end && last_stop;
  end
  always_ff @(posedge clk)
    if (reset) begin
      o_tx <= 1'b1;
      bus.o_tx_busy <= 1'b0;
      bus.o_tx_done <= 1'b0;
    end else begin
      o_tx <= tx_d;
      bus.o_tx_busy <= busy_d;
      bus.o_tx_done <= done_d;
    end
  always_ff @(posedge clk)
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      shift <= '0;
      parity <= 1'b0;
    end else begin
      if (accept) begin
        shift <= bus.i_tx_data;
        parity <= ^bus.i_tx_data ^ (PARITY_MODE == 2);
      end
      if (i_baud_tick) begin
        tick_cnt <= (state inside {IDLE, WAIT} || bit_end) ? '0 : tick_cnt + TW'(1);
        if (state == START && bit_end) bit_cnt <= '0;
        if (state == DATA && bit_end && !last_data) begin
          bit_cnt <= bit_cnt + BW'(1);
          shift <= shift >> 1;
        end
        stop_cnt <= state != STOP ? 1'b0 : stop_cnt ^ bit_end;
      end
    end
endmodule
